// File: rtl/dma_rd_sched.sv
// Read-side DMA scheduler: splits one read command into MRRS-limited, 4 KB-safe
// memory-read requests, each carrying a tag from a small pool, and retires the command.
module dma_rd_sched #(
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = 20,
  parameter int MRRS_DW  = 128,
  parameter int NUM_TAGS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len_dw,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [10:0]       req_len_dw,
  output logic [7:0]        req_tag,
  input  logic              cpl_done,
  input  logic [7:0]        cpl_tag,
  output logic              cmd_done,
  output logic              cpl_err,
  output logic [5:0]        outstanding,
  output logic              busy
);

  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [10:0]         req_len_q, req_len_d;
  logic [7:0]          req_tag_q, req_tag_d;
  logic [NUM_TAGS-1:0] used_q, used_d;
  logic [5:0]          out_q, out_d;
  logic                cmd_done_q, cmd_done_d;
  logic                cpl_err_q, cpl_err_d;

  logic                hs;
  logic                free_hit;
  logic [NUM_TAGS-1:0] free_mask, alloc_mask, avail, avail_b2b;
  logic [ADDR_W-1:0]   next_addr;
  logic [LEN_W-1:0]    next_rem;

  // Largest legal request starting at a: bounded by remaining length, MRRS and the 4 KB page.
  function automatic logic [CW-1:0] chunk_of(input logic [ADDR_W-1:0] a,
                                             input logic [LEN_W-1:0]  r);
    logic [12:0]   room_b;
    logic [CW-1:0] room;
    logic [CW-1:0] c;
    room_b = 13'h1000 - {1'b0, a[11:0]};
    room   = CW'(room_b[12:2]);
    c      = CW'(r);
    if (c > CW'(MRRS_DW)) c = CW'(MRRS_DW);
    if (c > room)         c = room;
    return c;
  endfunction

  function automatic logic [7:0] lowest(input logic [NUM_TAGS-1:0] m);
    logic [7:0] idx;
    idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (m[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    req_tag_d   = req_tag_q;
    cmd_done_d  = 1'b0;
    free_mask   = '0;
    alloc_mask  = '0;

    hs = req_valid_q && req_ready;
    for (int i = 0; i < NUM_TAGS; i++) begin
      free_mask[i]  = cpl_done && (cpl_tag == 8'(i)) && used_q[i];
      alloc_mask[i] = hs && (req_tag_q == 8'(i));
    end
    free_hit  = |free_mask;
    cpl_err_d = cpl_done && !free_hit;
    used_d    = (used_q | alloc_mask) & ~free_mask;
    out_d     = out_q + 6'(hs) - 6'(free_hit);

    // A tag freed this cycle is already usable for the request raised at this edge.
    avail     = ~used_q | free_mask;
    avail_b2b = avail & ~alloc_mask;
    next_addr = addr_q + ADDR_W'({req_len_q, 2'b00});
    next_rem  = rem_q - LEN_W'(req_len_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_ISSUE;
          addr_d  = cmd_addr;
          rem_d   = cmd_len_dw;
          if (|avail) begin
            req_valid_d = 1'b1;
            req_addr_d  = cmd_addr;
            req_len_d   = 11'(chunk_of(cmd_addr, cmd_len_dw));
            req_tag_d   = lowest(avail);
          end
        end
      end
      S_ISSUE: begin
        if (hs) begin
          addr_d = next_addr;
          rem_d  = next_rem;
          if (next_rem == '0) begin
            state_d     = S_DRAIN;
            req_valid_d = 1'b0;
          end else if (|avail_b2b) begin
            req_valid_d = 1'b1;
            req_addr_d  = next_addr;
            req_len_d   = 11'(chunk_of(next_addr, next_rem));
            req_tag_d   = lowest(avail_b2b);
          end else begin
            req_valid_d = 1'b0;
          end
        end else if (!req_valid_q && (|avail)) begin
          req_valid_d = 1'b1;
          req_addr_d  = addr_q;
          req_len_d   = 11'(chunk_of(addr_q, rem_q));
          req_tag_d   = lowest(avail);
        end
      end
      S_DRAIN: begin
        if (out_d == '0) begin
          state_d    = S_IDLE;
          cmd_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the tag bitmap is control state, not data storage, so it is reset with everything else.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      req_tag_q   <= '0;
      used_q      <= '0;
      out_q       <= '0;
      cmd_done_q  <= 1'b0;
      cpl_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      req_tag_q   <= req_tag_d;
      used_q      <= used_d;
      out_q       <= out_d;
      cmd_done_q  <= cmd_done_d;
      cpl_err_q   <= cpl_err_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign req_valid   = req_valid_q;
  assign req_addr    = req_addr_q;
  assign req_len_dw  = req_len_q;
  assign req_tag     = req_tag_q;
  assign cmd_done    = cmd_done_q;
  assign cpl_err     = cpl_err_q;
  assign outstanding = out_q;

endmodule

// File: tb/tb_dma_rd_sched.sv
// Directed bench for dma_rd_sched with a 4-entry tag pool and 128 DW MRRS.
module tb_dma_rd_sched;

  logic        i_clk;
  logic        i_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [19:0] cmd_len_dw;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [10:0] req_len_dw;
  logic [7:0]  req_tag;
  logic        cpl_done;
  logic [7:0]  cpl_tag;
  logic        cmd_done;
  logic        cpl_err;
  logic [5:0]  outstanding;
  logic        busy;

  int total = 0;
  int bad   = 0;

  dma_rd_sched #(
    .ADDR_W  (64),
    .LEN_W   (20),
    .MRRS_DW (128),
    .NUM_TAGS(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len_dw (cmd_len_dw),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len_dw (req_len_dw),
    .req_tag    (req_tag),
    .cpl_done   (cpl_done),
    .cpl_tag    (cpl_tag),
    .cmd_done   (cmd_done),
    .cpl_err    (cpl_err),
    .outstanding(outstanding),
    .busy       (busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic [63:0] a,
                           input logic [10:0] l, input logic [7:0] t);
    check({tag, ".valid"}, 64'(req_valid), 64'd1);
    check({tag, ".addr"},  req_addr, a);
    check({tag, ".len"},   64'(req_len_dw), 64'(l));
    check({tag, ".tag"},   64'(req_tag), 64'(t));
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [19:0] l);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len_dw = l;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic complete(input logic [7:0] t);
    cpl_done = 1'b1;
    cpl_tag  = t;
    tick();
    cpl_done = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    i_rst_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len_dw = '0;
    req_ready  = 1'b0;
    cpl_done   = 1'b0;
    cpl_tag    = '0;
    #3;
    check("rst.req_valid", 64'(req_valid), 64'd0);
    check("rst.outstanding", 64'(outstanding), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    check("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.cmd_done", 64'(cmd_done), 64'd0);
    check("rst.cpl_err", 64'(cpl_err), 64'd0);
    check("rst.req_addr", req_addr, 64'd0);
    check("rst.req_len", 64'(req_len_dw), 64'd0);
    check("rst.req_tag", 64'(req_tag), 64'd0);

    // Single request inside one page.
    send_cmd(64'h1000, 20'd64);
    check("t1.cmd_ready", 64'(cmd_ready), 64'd0);
    check("t1.busy", 64'(busy), 64'd1);
    check_req("t1.r0", 64'h1000, 11'd64, 8'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("t1.valid_after", 64'(req_valid), 64'd0);
    check("t1.outstanding", 64'(outstanding), 64'd1);
    complete(8'd0);
    check("t1.cmd_done", 64'(cmd_done), 64'd1);
    check("t1.cmd_ready_done", 64'(cmd_ready), 64'd1);
    check("t1.outstanding0", 64'(outstanding), 64'd0);
    tick();
    check("t1.cmd_done_pulse", 64'(cmd_done), 64'd0);

    // Exactly MRRS on a 4 KB-aligned address: a single request.
    send_cmd(64'h2000, 20'd128);
    check_req("t1b.r0", 64'h2000, 11'd128, 8'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("t1b.valid_after", 64'(req_valid), 64'd0);
    check("t1b.busy", 64'(busy), 64'd1);
    complete(8'd0);
    check("t1b.cmd_done", 64'(cmd_done), 64'd1);
    tick();

    // 4 KB crossing: split into 4 + 12 DW, back-to-back.
    send_cmd(64'h0FF0, 20'd16);
    check_req("t2.r0", 64'h0FF0, 11'd4, 8'd0);
    req_ready = 1'b1;
    tick();
    check_req("t2.r1", 64'h1000, 11'd12, 8'd1);
    check("t2.out1", 64'(outstanding), 64'd1);
    tick();
    req_ready = 1'b0;
    check("t2.valid_after", 64'(req_valid), 64'd0);
    check("t2.out2", 64'(outstanding), 64'd2);
    complete(8'd0);
    check("t2.no_done_yet", 64'(cmd_done), 64'd0);
    complete(8'd1);
    check("t2.cmd_done", 64'(cmd_done), 64'd1);
    tick();

    // Stray completions: free tag and out-of-range tag.
    complete(8'd1);
    check("t5.err_free", 64'(cpl_err), 64'd1);
    check("t5.out_free", 64'(outstanding), 64'd0);
    tick();
    check("t5.err_pulse", 64'(cpl_err), 64'd0);
    complete(8'd9);
    check("t5.err_range", 64'(cpl_err), 64'd1);
    check("t5.out_range", 64'(outstanding), 64'd0);
    tick();

    // Tag exhaustion, then reuse of a freed tag.
    req_ready = 1'b1;
    send_cmd(64'h0, 20'd1000);
    check_req("t3.r0", 64'h000, 11'd128, 8'd0);
    tick();
    check_req("t3.r1", 64'h200, 11'd128, 8'd1);
    tick();
    check_req("t3.r2", 64'h400, 11'd128, 8'd2);
    tick();
    check_req("t3.r3", 64'h600, 11'd128, 8'd3);
    tick();
    req_ready = 1'b0;
    check("t3.stall_valid", 64'(req_valid), 64'd0);
    check("t3.stall_out", 64'(outstanding), 64'd4);
    tick();
    check("t3.stall_hold", 64'(req_valid), 64'd0);
    complete(8'd2);
    check_req("t3.r4", 64'h800, 11'd128, 8'd2);
    check("t3.out3", 64'(outstanding), 64'd3);

    // Stalled request keeps its fields while a lower tag frees.
    complete(8'd0);
    check("t4.out2", 64'(outstanding), 64'd2);
    check_req("t4.hold0", 64'h800, 11'd128, 8'd2);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_req("t4.hold", 64'h800, 11'd128, 8'd2);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check_req("t4.r5", 64'hA00, 11'd128, 8'd0);
    check("t4.out3", 64'(outstanding), 64'd3);
    do_reset();

    // Reset in DRAIN with three tags outstanding.
    req_ready = 1'b1;
    send_cmd(64'h0, 20'd384);
    check_req("t6.r0", 64'h000, 11'd128, 8'd0);
    tick();
    tick();
    check_req("t6.r2", 64'h400, 11'd128, 8'd2);
    tick();
    req_ready = 1'b0;
    check("t6.drain_valid", 64'(req_valid), 64'd0);
    check("t6.drain_out", 64'(outstanding), 64'd3);
    check("t6.drain_busy", 64'(busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 64'(req_valid), 64'd0);
    check("t6.rst_out", 64'(outstanding), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    check("t6.cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6.busy", 64'(busy), 64'd0);
    complete(8'd1);
    check("t6.stale_err", 64'(cpl_err), 64'd1);
    check("t6.stale_out", 64'(outstanding), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
